bcd_counter_modn: RTL and testbench

//   Parametrised synchronous BCD modulo-N counter: successor to the fixed mod-24 hour counter.

---
 rtl/bcd_counter_modn_pkg.sv | 50 +++++
 rtl/bcd_counter_modn_digit.sv | 69 ++++++
 rtl/bcd_counter_modn.sv | 113 +++++++++++
 tb/tb_bcd_counter_modn.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_counter_modn_pkg.sv
// Shared definitions for the BCD modulo-N counter.
//   BCD_MAX_DIGIT / BCD_ZERO : digit limits used by the digit cells
//   digit_op_e               : per-digit update selection
//   pow10, bin_to_bcd, bcd_to_bin : constant helpers that derive the BCD
//                                   image of MODULUS-1 at elaboration
package bcd_counter_modn_pkg;

    localparam logic [3:0] BCD_MAX_DIGIT  = 4'd9;
    localparam logic [3:0] BCD_ZERO       = 4'd0;
    localparam int         BCD_MAX_DIGITS = 4;
    localparam int         BCD_BUS_W      = 4 * BCD_MAX_DIGITS;

    typedef enum logic [1:0] {
        DIG_HOLD,
        DIG_LOAD,
        DIG_WRAP,
        DIG_STEP
    } digit_op_e;

    function automatic int pow10(input int n);
        int r;
        r = 1;
        for (int i = 0; i < n; i++) begin
            r = r * 10;
        end
        return r;
    endfunction

    function automatic logic [BCD_BUS_W-1:0] bin_to_bcd(input int value);
        logic [BCD_BUS_W-1:0] r;
        int                   v;
        r = '0;
        v = value;
        for (int i = 0; i < BCD_MAX_DIGITS; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    function automatic int bcd_to_bin(input logic [BCD_BUS_W-1:0] bcd);
        int v;
        v = 0;
        for (int i = BCD_MAX_DIGITS - 1; i >= 0; i--) begin
            v = v * 10 + int'(bcd[4*i +: 4]);
        end
        return v;
    endfunction

endpackage

// File: rtl/bcd_counter_modn_digit.sv
// One BCD digit cell of the modulo-N counter.
//   clk, clr        : clock, synchronous active-high clear
//   load/load_digit : parallel load (value already validated by the top)
//   wrap/wrap_digit : forced modulus wrap value for this digit
//   step/up         : step this digit (carry or borrow in) and direction
//   q               : digit value
//   step_out        : carry (up) or borrow (down) into the next digit
module bcd_digit
    import bcd_counter_modn_pkg::*;
(
    input  logic       clk,
    input  logic       clr,
    input  logic       load,
    input  logic [3:0] load_digit,
    input  logic       wrap,
    input  logic [3:0] wrap_digit,
    input  logic       step,
    input  logic       up,
    output logic [3:0] q,
    output logic       step_out
);

    logic [3:0] q_q;
    logic [3:0] q_d;
    digit_op_e  op;

    always_comb begin
        op = DIG_HOLD;
        if (load) begin
            op = DIG_LOAD;
        end else if (wrap) begin
            op = DIG_WRAP;
        end else if (step) begin
            op = DIG_STEP;
        end
    end

    // Carry/borrow only ripples while this digit itself is being stepped.
    always_comb begin
        step_out = step & (up ? (q_q == BCD_MAX_DIGIT) : (q_q == BCD_ZERO));
    end

    always_comb begin
        q_d = q_q;
        case (op)
            DIG_LOAD: q_d = load_digit;
            DIG_WRAP: q_d = wrap_digit;
            DIG_STEP: begin
                if (up) begin
                    q_d = (q_q == BCD_MAX_DIGIT) ? BCD_ZERO : q_q + 4'd1;
                end else begin
                    q_d = (q_q == BCD_ZERO) ? BCD_MAX_DIGIT : q_q - 4'd1;
                end
            end
            default: q_d = q_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            q_q <= BCD_ZERO;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/bcd_counter_modn.sv
// Parametrised BCD modulo-N up/down counter with validated parallel load.
//   clk      : clock, rising edge
//   clr      : synchronous active-high clear (wins over everything)
//   en, up   : count enable and direction
//   load     : synchronous load of load_val (beats en)
//   load_val : BCD load value, digit 0 in [3:0]
//   q        : BCD count, digit k in [4k+3:4k]
//   tc       : combinational terminal count, high when the next step wraps
//   load_err : high for one cycle after a rejected load
module bcd_counter_modn
    import bcd_counter_modn_pkg::*;
#(
    parameter int DIGITS  = 2,
    parameter int MODULUS = 24
) (
    input  logic                clk,
    input  logic                clr,
    input  logic                en,
    input  logic                up,
    input  logic                load,
    input  logic [4*DIGITS-1:0] load_val,
    output logic [4*DIGITS-1:0] q,
    output logic                tc,
    output logic                load_err
);

    localparam int           W       = 4 * DIGITS;
    localparam logic [W-1:0] MAX_BCD = W'(bin_to_bcd(MODULUS - 1));

    if (DIGITS < 1 || DIGITS > BCD_MAX_DIGITS) begin : g_bad_digits
        $error("bcd_counter_modn: DIGITS must be 1..4");
    end
    if (MODULUS < 2 || MODULUS > pow10(DIGITS)) begin : g_bad_modulus
        $error("bcd_counter_modn: MODULUS must be 2..10**DIGITS");
    end
    if (bcd_to_bin(BCD_BUS_W'(MAX_BCD)) != MODULUS - 1) begin : g_bad_max
        $error("bcd_counter_modn: MODULUS-1 does not fit in DIGITS");
    end

    logic         digits_ok;
    logic         load_ok;
    logic [W-1:0] load_digits;
    logic [W-1:0] wrap_val;
    logic         step_lsd;
    logic         at_max;
    logic         load_err_q;
    logic         load_err_d;

    always_comb begin
        digits_ok = 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
            if (load_val[4*k +: 4] > BCD_MAX_DIGIT) begin
                digits_ok = 1'b0;
            end
        end
    end

    // With every digit <= 9, BCD ordering matches numeric ordering, so the
    // range check is a plain unsigned compare against MODULUS-1 in BCD.
    always_comb begin
        load_ok     = digits_ok & (load_val <= MAX_BCD);
        load_digits = load_ok ? load_val : '0;
        wrap_val    = up ? '0 : MAX_BCD;
        step_lsd    = en & ~load;
        at_max      = (q == MAX_BCD);
    end

    for (genvar k = 0; k < DIGITS; k++) begin : g_digit
        logic step_in;
        logic step_out;

        if (k == 0) begin : g_lsd
            assign step_in = step_lsd;
        end else begin : g_upper
            assign step_in = g_digit[k-1].step_out;
        end

        bcd_digit u_digit (
            .clk        (clk),
            .clr        (clr),
            .load       (load),
            .load_digit (load_digits[4*k +: 4]),
            .wrap       (tc),
            .wrap_digit (wrap_val[4*k +: 4]),
            .step       (step_in),
            .up         (up),
            .q          (q[4*k +: 4]),
            .step_out   (step_out)
        );
    end

    // Counting down, a borrow out of the top digit happens exactly when q is
    // all zeros, so the ripple output doubles as the down-wrap detector.
    // Counting up, MODULUS-1 may sit below the all-9s pattern, so compare.
    always_comb begin
        tc = ~clr & (up ? (step_lsd & at_max) : g_digit[DIGITS-1].step_out);
    end

    always_comb begin
        load_err_d = load & ~load_ok;
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            load_err_q <= 1'b0;
        end else begin
            load_err_q <= load_err_d;
        end
    end

    assign load_err = load_err_q;

endmodule

// File: tb/tb_bcd_counter_modn.sv
module tb_bcd_counter_modn;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        clr, en, up, load;
    logic [11:0] lv;
    logic        en_c, load_c;
    logic [7:0]  lv_s, lv_h;

    logic [7:0]  q24, q60, qs, qh;
    logic [11:0] q1k;
    logic        tc24, tc60, tc1k, tcs, tch;
    logic        er24, er60, er1k, ers, erh;

    bcd_counter_modn #(.DIGITS(2), .MODULUS(24)) u_m24 (
        .clk(clk), .clr(clr), .en(en), .up(up), .load(load), .load_val(lv[7:0]),
        .q(q24), .tc(tc24), .load_err(er24));
    bcd_counter_modn #(.DIGITS(2), .MODULUS(60)) u_m60 (
        .clk(clk), .clr(clr), .en(en), .up(up), .load(load), .load_val(lv[7:0]),
        .q(q60), .tc(tc60), .load_err(er60));
    bcd_counter_modn #(.DIGITS(3), .MODULUS(1000)) u_m1k (
        .clk(clk), .clr(clr), .en(en), .up(up), .load(load), .load_val(lv),
        .q(q1k), .tc(tc1k), .load_err(er1k));
    bcd_counter_modn #(.DIGITS(2), .MODULUS(60)) u_sec (
        .clk(clk), .clr(clr), .en(en_c), .up(up), .load(load_c), .load_val(lv_s),
        .q(qs), .tc(tcs), .load_err(ers));
    bcd_counter_modn #(.DIGITS(2), .MODULUS(24)) u_hr (
        .clk(clk), .clr(clr), .en(tcs), .up(up), .load(load_c), .load_val(lv_h),
        .q(qh), .tc(tch), .load_err(erh));

    int checks = 0;
    int errors = 0;
    bit chk_on = 1'b0;

    // Reference model: counter values held as plain integers.
    int m24, m60, m1k, ms, mh;
    bit e24, e60, e1k, es, eh;

    function automatic int bcd_val(input logic [15:0] x, input int digits);
        int v;
        v = 0;
        for (int i = digits - 1; i >= 0; i--) begin
            if (x[4*i +: 4] > 4'd9) return -1;
            v = v * 10 + int'(x[4*i +: 4]);
        end
        return v;
    endfunction

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        int t;
        r = '0;
        t = v;
        for (int i = 0; i < 4; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic bit ld_ok(input logic [15:0] x, input int digits, input int md);
        int v;
        v = bcd_val(x, digits);
        return (v >= 0) && (v < md);
    endfunction

    function automatic bit m_tc(input int v, input int md, input bit c, input bit l,
                                input bit e, input bit u);
        return e && !c && !l && (u ? (v == md - 1) : (v == 0));
    endfunction

    function automatic int m_next(input int v, input int md, input int digits,
                                  input logic [15:0] x, input bit c, input bit l,
                                  input bit e, input bit u);
        if (c) return 0;
        if (l) return ld_ok(x, digits, md) ? bcd_val(x, digits) : 0;
        if (e) return u ? (v + 1) % md : (v + md - 1) % md;
        return v;
    endfunction

    function automatic bit m_err(input int md, input int digits, input logic [15:0] x,
                                 input bit c, input bit l);
        return !c && l && !ld_ok(x, digits, md);
    endfunction

    always @(posedge clk) begin
        bit en_h;
        en_h = m_tc(ms, 60, clr, load_c, en_c, up);
        e24 = m_err(24, 2, 16'(lv[7:0]), clr, load);
        m24 = m_next(m24, 24, 2, 16'(lv[7:0]), clr, load, en, up);
        e60 = m_err(60, 2, 16'(lv[7:0]), clr, load);
        m60 = m_next(m60, 60, 2, 16'(lv[7:0]), clr, load, en, up);
        e1k = m_err(1000, 3, 16'(lv), clr, load);
        m1k = m_next(m1k, 1000, 3, 16'(lv), clr, load, en, up);
        es  = m_err(60, 2, 16'(lv_s), clr, load_c);
        ms  = m_next(ms, 60, 2, 16'(lv_s), clr, load_c, en_c, up);
        eh  = m_err(24, 2, 16'(lv_h), clr, load_c);
        mh  = m_next(mh, 24, 2, 16'(lv_h), clr, load_c, en_h, up);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            chk("m24_q",   32'(q24),  32'(8'(to_bcd(m24))));
            chk("m24_tc",  32'(tc24), 32'(m_tc(m24, 24, clr, load, en, up)));
            chk("m24_err", 32'(er24), 32'(e24));
            chk("m60_q",   32'(q60),  32'(8'(to_bcd(m60))));
            chk("m60_tc",  32'(tc60), 32'(m_tc(m60, 60, clr, load, en, up)));
            chk("m60_err", 32'(er60), 32'(e60));
            chk("m1k_q",   32'(q1k),  32'(12'(to_bcd(m1k))));
            chk("m1k_tc",  32'(tc1k), 32'(m_tc(m1k, 1000, clr, load, en, up)));
            chk("m1k_err", 32'(er1k), 32'(e1k));
            chk("sec_q",   32'(qs),   32'(8'(to_bcd(ms))));
            chk("sec_tc",  32'(tcs),  32'(m_tc(ms, 60, clr, load_c, en_c, up)));
            chk("sec_err", 32'(ers),  32'(es));
            chk("hr_q",    32'(qh),   32'(8'(to_bcd(mh))));
            chk("hr_tc",   32'(tch),
                32'(m_tc(mh, 24, clr, load_c, m_tc(ms, 60, clr, load_c, en_c, up), up)));
            chk("hr_err",  32'(erh),  32'(eh));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        clr = 1'b1; en = 1'b0; up = 1'b1; load = 1'b0; lv = '0;
        en_c = 1'b0; load_c = 1'b0; lv_s = '0; lv_h = '0;
        tick();
        chk_on = 1'b1;
        chk("rst_q24", 32'(q24), 32'h00);
        chk("rst_err24", 32'(er24), 32'h0);
        tick();
        clr = 1'b0;

        // Up count through the full mod-24 range and back to 00.
        en = 1'b1; up = 1'b1;
        for (int i = 0; i < 24; i++) begin
            if (i == 22) chk("up_tc_at22", 32'(tc24), 32'h0);
            if (i == 23) begin
                chk("up_q23", 32'(q24), 32'h23);
                chk("up_tc_at23", 32'(tc24), 32'h1);
            end
            tick();
        end
        chk("up_wrap_00", 32'(q24), 32'h00);

        // Down from 00 wraps to 23, then 22.
        up = 1'b0;
        #1;
        chk("dn_tc_at00", 32'(tc24), 32'h1);
        tick();
        chk("dn_wrap_23", 32'(q24), 32'h23);
        tick();
        chk("dn_22", 32'(q24), 32'h22);

        // Load validation.
        en = 1'b0; load = 1'b1; lv = 12'h059;
        tick();
        chk("ld59_q60", 32'(q60), 32'h59);
        chk("ld59_err60", 32'(er60), 32'h0);
        chk("ld59_q24", 32'(q24), 32'h00);
        chk("ld59_err24", 32'(er24), 32'h1);
        lv = 12'h060;
        tick();
        chk("ld60_q60", 32'(q60), 32'h00);
        chk("ld60_err60", 32'(er60), 32'h1);
        load = 1'b0;
        tick();
        chk("err_one_cycle", 32'(er60), 32'h0);
        load = 1'b1; lv = 12'h03A;
        tick();
        chk("ld3A_q60", 32'(q60), 32'h00);
        chk("ld3A_err60", 32'(er60), 32'h1);

        // Carry and borrow across digits.
        lv = 12'h009;
        tick();
        load = 1'b0; en = 1'b1; up = 1'b1;
        tick();
        chk("carry_10", 32'(q24), 32'h10);
        up = 1'b0;
        tick();
        chk("borrow_09", 32'(q24), 32'h09);
        en = 1'b0; load = 1'b1; lv = 12'h999;
        tick();
        chk("ld999", 32'(q1k), 32'h999);
        load = 1'b0; en = 1'b1; up = 1'b1;
        #1;
        chk("tc_999", 32'(tc1k), 32'h1);
        tick();
        chk("wrap_999_000", 32'(q1k), 32'h000);

        // clr beats load and en; then load beats en.
        en = 1'b0; load = 1'b1; lv = 12'h015;
        tick();
        chk("ld15", 32'(q24), 32'h15);
        clr = 1'b1; en = 1'b1; lv = 12'h007;
        tick();
        chk("clr_win_q", 32'(q24), 32'h00);
        chk("clr_win_err", 32'(er24), 32'h0);
        clr = 1'b0; up = 1'b0; lv = 12'h012;
        #1;
        chk("ld_en_tc0", 32'(tc24), 32'h0);
        tick();
        chk("ld_en_q12", 32'(q24), 32'h12);
        load = 1'b0; en = 1'b0;

        // Cascade seconds (mod 60) into hours (mod 24).
        load_c = 1'b1; lv_s = 8'h59; lv_h = 8'h23; up = 1'b1;
        tick();
        chk("casc_ld_s", 32'(qs), 32'h59);
        chk("casc_ld_h", 32'(qh), 32'h23);
        load_c = 1'b0; en_c = 1'b1;
        #1;
        chk("casc_tc_s", 32'(tcs), 32'h1);
        chk("casc_tc_h", 32'(tch), 32'h1);
        tick();
        chk("casc_s_00", 32'(qs), 32'h00);
        chk("casc_h_00", 32'(qh), 32'h00);

        // Randomised traffic against the model.
        for (int n = 0; n < 2000; n++) begin
            clr    = ($urandom_range(0, 63) == 0);
            load   = ($urandom_range(0, 7) == 0);
            lv     = ($urandom_range(0, 1) == 1) ? 12'(to_bcd(int'($urandom_range(0, 999))))
                                                 : 12'($urandom);
            en     = ($urandom_range(0, 3) != 0);
            up     = ($urandom_range(0, 1) == 1);
            en_c   = ($urandom_range(0, 3) != 0);
            load_c = ($urandom_range(0, 15) == 0);
            lv_s   = ($urandom_range(0, 1) == 1) ? 8'(to_bcd(int'($urandom_range(0, 99))))
                                                 : 8'($urandom);
            lv_h   = 8'(to_bcd(int'($urandom_range(0, 29))));
            tick();
        end

        clr = 1'b0; load = 1'b0; en = 1'b0; en_c = 1'b0; load_c = 1'b0;
        tick();
        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
